// File: rtl/stage_ex_md_pkg.sv
// rtl/stage_ex_md_pkg.sv - shared encodings, FSM state type and default widths for the execute stage
package stage_ex_md_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int PC_W_DEF   = 30;
   localparam int GPR_AW_DEF = 5;

   localparam logic [3:0] ALU_PASS = 4'd0;
   localparam logic [3:0] ALU_AND  = 4'd1;
   localparam logic [3:0] ALU_OR   = 4'd2;
   localparam logic [3:0] ALU_XOR  = 4'd3;
   localparam logic [3:0] ALU_ADDS = 4'd4;
   localparam logic [3:0] ALU_ADDU = 4'd5;
   localparam logic [3:0] ALU_SUBS = 4'd6;
   localparam logic [3:0] ALU_SUBU = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SLL  = 4'd9;

   localparam logic [1:0] MD_NONE = 2'd0;
   localparam logic [1:0] MD_MUL  = 2'd1;
   localparam logic [1:0] MD_DIVU = 2'd2;
   localparam logic [1:0] MD_REMU = 2'd3;

   localparam logic [2:0] EXP_NONE = 3'd0;
   localparam logic [2:0] EXP_INT  = 3'd1;
   localparam logic [2:0] EXP_OVF  = 3'd3;

   typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;
endpackage

// File: rtl/stage_ex_md_md_iter.sv
// rtl/stage_ex_md_md_iter.sv - iterative MUL/DIVU/REMU unit, one bit per cycle over DATA_W cycles
module md_iter import stage_ex_md_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              flush,
   input  logic              hold,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);
   localparam int CW = $clog2(DATA_W);

   md_state_e         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [DATA_W-1:0] y_q, y_d;
   logic [DATA_W:0]   rem_sh, rem_diff;

   // acc holds product (MUL) or partial remainder; x holds multiplicand or dividend/quotient
   assign rem_sh   = {acc_q, x_q[DATA_W-1]};
   assign rem_diff = rem_sh - {1'b0, y_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      if (flush) begin
         state_d = MD_IDLE;
      end else begin
         case (state_q)
            MD_IDLE: if (start) begin
               state_d = MD_RUN;
               cnt_d   = '0;
               op_d    = op;
               acc_d   = '0;
               x_d     = opa;
               y_d     = opb;
            end
            MD_RUN: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(DATA_W - 1)) state_d = MD_DONE;
               if (op_q == MD_MUL) begin
                  if (y_q[0]) acc_d = acc_q + x_q;
                  x_d = x_q << 1;
                  y_d = y_q >> 1;
               end else if (!rem_diff[DATA_W]) begin
                  acc_d = rem_diff[DATA_W-1:0];
                  x_d   = {x_q[DATA_W-2:0], 1'b1};
               end else begin
                  acc_d = rem_sh[DATA_W-1:0];
                  x_d   = {x_q[DATA_W-2:0], 1'b0};
               end
            end
            default: if (!hold) state_d = MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_NONE;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign busy   = reset & (((state_q == MD_IDLE) & start) | (state_q == MD_RUN));
   assign done   = (state_q == MD_DONE);
   assign result = (op_q == MD_DIVU) ? x_q : acc_q;
endmodule

// File: rtl/stage_ex_md.sv
// rtl/stage_ex_md.sv - execute stage: single-cycle ALU, iterative MDU and EX/MEM pipeline register
module stage_ex_md import stage_ex_md_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PC_W   = PC_W_DEF,
   parameter int GPR_AW = GPR_AW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              int_detect,
   input  logic [PC_W-1:0]   id_pc,
   input  logic              id_en,
   input  logic              id_br_flag,
   input  logic [3:0]        id_alu_op,
   input  logic [DATA_W-1:0] id_alu_in_0,
   input  logic [DATA_W-1:0] id_alu_in_1,
   input  logic [1:0]        id_md_op,
   input  logic [1:0]        id_mem_op,
   input  logic [DATA_W-1:0] id_mem_wr_data,
   input  logic [1:0]        id_ctrl_op,
   input  logic [GPR_AW-1:0] id_dst_addr,
   input  logic              id_gpr_we_,
   input  logic [2:0]        id_exp_code,
   output logic [PC_W-1:0]   ex_pc,
   output logic              ex_en,
   output logic              ex_br_flag,
   output logic [1:0]        ex_mem_op,
   output logic [DATA_W-1:0] ex_mem_wr_data,
   output logic [1:0]        ex_ctrl_op,
   output logic [GPR_AW-1:0] ex_dst_addr,
   output logic              ex_gpr_we_,
   output logic [2:0]        ex_exp_code,
   output logic [DATA_W-1:0] ex_out,
   output logic              ex_busy
);
   localparam int SHW = $clog2(DATA_W);
   localparam int MSB = DATA_W - 1;

   logic [DATA_W-1:0] alu_sum, alu_diff, alu_out, md_result;
   logic              alu_ovf, md_start, md_busy, md_done;

   logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
   logic              ex_en_q, ex_en_d, ex_br_flag_q, ex_br_flag_d;
   logic [1:0]        ex_mem_op_q, ex_mem_op_d, ex_ctrl_op_q, ex_ctrl_op_d;
   logic [DATA_W-1:0] ex_mem_wr_data_q, ex_mem_wr_data_d, ex_out_q, ex_out_d;
   logic [GPR_AW-1:0] ex_dst_addr_q, ex_dst_addr_d;
   logic              ex_gpr_we_q, ex_gpr_we_d;
   logic [2:0]        ex_exp_code_q, ex_exp_code_d;

   assign alu_sum  = id_alu_in_0 + id_alu_in_1;
   assign alu_diff = id_alu_in_0 - id_alu_in_1;

   always_comb begin
      alu_out = '0;
      alu_ovf = 1'b0;
      case (id_alu_op)
         ALU_PASS: alu_out = id_alu_in_0;
         ALU_AND:  alu_out = id_alu_in_0 & id_alu_in_1;
         ALU_OR:   alu_out = id_alu_in_0 | id_alu_in_1;
         ALU_XOR:  alu_out = id_alu_in_0 ^ id_alu_in_1;
         ALU_ADDS: begin
            alu_out = alu_sum;
            alu_ovf = (id_alu_in_0[MSB] == id_alu_in_1[MSB]) && (alu_sum[MSB] != id_alu_in_0[MSB]);
         end
         ALU_ADDU: alu_out = alu_sum;
         ALU_SUBS: begin
            alu_out = alu_diff;
            alu_ovf = (id_alu_in_0[MSB] != id_alu_in_1[MSB]) && (alu_diff[MSB] != id_alu_in_0[MSB]);
         end
         ALU_SUBU: alu_out = alu_diff;
         ALU_SRL:  alu_out = id_alu_in_0 >> id_alu_in_1[SHW-1:0];
         ALU_SLL:  alu_out = id_alu_in_0 << id_alu_in_1[SHW-1:0];
         default:  alu_out = '0;
      endcase
   end

   assign md_start = id_en & (id_md_op != MD_NONE) & ~flush & ~int_detect;

   md_iter #(.DATA_W(DATA_W)) u_md_iter (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start),
      .flush  (flush | int_detect),
      .hold   (stall),
      .op     (id_md_op),
      .opa    (id_alu_in_0),
      .opb    (id_alu_in_1),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   // Fields default to the bubble; each priority level below overrides only what it carries.
   always_comb begin
      ex_pc_d          = '0;
      ex_en_d          = 1'b0;
      ex_br_flag_d     = 1'b0;
      ex_mem_op_d      = '0;
      ex_mem_wr_data_d = '0;
      ex_ctrl_op_d     = '0;
      ex_dst_addr_d    = '0;
      ex_gpr_we_d      = 1'b1;
      ex_exp_code_d    = EXP_NONE;
      ex_out_d         = '0;
      if (stall) begin
         ex_pc_d          = ex_pc_q;
         ex_en_d          = ex_en_q;
         ex_br_flag_d     = ex_br_flag_q;
         ex_mem_op_d      = ex_mem_op_q;
         ex_mem_wr_data_d = ex_mem_wr_data_q;
         ex_ctrl_op_d     = ex_ctrl_op_q;
         ex_dst_addr_d    = ex_dst_addr_q;
         ex_gpr_we_d      = ex_gpr_we_q;
         ex_exp_code_d    = ex_exp_code_q;
         ex_out_d         = ex_out_q;
      end else if (flush) begin
         ex_en_d = 1'b0;
      end else if (int_detect) begin
         ex_pc_d       = id_pc;
         ex_en_d       = id_en;
         ex_br_flag_d  = id_br_flag;
         ex_exp_code_d = EXP_INT;
      end else if ((id_md_op != MD_NONE) && md_busy) begin
         ex_en_d = 1'b0;
      end else if ((id_md_op == MD_NONE) && alu_ovf) begin
         ex_pc_d       = id_pc;
         ex_en_d       = id_en;
         ex_br_flag_d  = id_br_flag;
         ex_exp_code_d = EXP_OVF;
      end else begin
         ex_pc_d          = id_pc;
         ex_en_d          = id_en;
         ex_br_flag_d     = id_br_flag;
         ex_mem_op_d      = id_mem_op;
         ex_mem_wr_data_d = id_mem_wr_data;
         ex_ctrl_op_d     = id_ctrl_op;
         ex_dst_addr_d    = id_dst_addr;
         ex_gpr_we_d      = id_gpr_we_;
         ex_exp_code_d    = id_exp_code;
         ex_out_d         = md_done ? md_result : alu_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_pc_q          <= '0;
         ex_en_q          <= 1'b0;
         ex_br_flag_q     <= 1'b0;
         ex_mem_op_q      <= '0;
         ex_mem_wr_data_q <= '0;
         ex_ctrl_op_q     <= '0;
         ex_dst_addr_q    <= '0;
         ex_gpr_we_q      <= 1'b1;
         ex_exp_code_q    <= EXP_NONE;
         ex_out_q         <= '0;
      end else begin
         ex_pc_q          <= ex_pc_d;
         ex_en_q          <= ex_en_d;
         ex_br_flag_q     <= ex_br_flag_d;
         ex_mem_op_q      <= ex_mem_op_d;
         ex_mem_wr_data_q <= ex_mem_wr_data_d;
         ex_ctrl_op_q     <= ex_ctrl_op_d;
         ex_dst_addr_q    <= ex_dst_addr_d;
         ex_gpr_we_q      <= ex_gpr_we_d;
         ex_exp_code_q    <= ex_exp_code_d;
         ex_out_q         <= ex_out_d;
      end
   end

   assign ex_pc          = ex_pc_q;
   assign ex_en          = ex_en_q;
   assign ex_br_flag     = ex_br_flag_q;
   assign ex_mem_op      = ex_mem_op_q;
   assign ex_mem_wr_data = ex_mem_wr_data_q;
   assign ex_ctrl_op     = ex_ctrl_op_q;
   assign ex_dst_addr    = ex_dst_addr_q;
   assign ex_gpr_we_     = ex_gpr_we_q;
   assign ex_exp_code    = ex_exp_code_q;
   assign ex_out         = ex_out_q;
   assign ex_busy        = md_busy;
endmodule
